booth_multiplier: RTL

Sequential radix-2 Booth multiplier producing the signed two's-complement product of two N-bit operands. It sits directly upstream of `sign_magnitude`. Its `mult_result` and `mult_ready` drive that stage's `mult_result` and `valid` inputs, replacing the fixed test-number source in the display chain. One Booth iteration runs per clock, so the arithmetic datapath is one adder of width N+1.

---
 rtl/booth_multiplier.sv | 134 +++++++++++++
 1 files changed

// File: rtl/booth_multiplier.sv
// -----------------------------------------------------------------------------
// booth_multiplier
//
// Sequential radix-2 Booth multiplier. It returns the signed two's-complement
// product of two N-bit operands after N iterations, one per clock. The
// arithmetic datapath is a single (N+1)-bit add/subtract.
//
// Ports
//   clk           system clock, rising-edge active
//   reset         synchronous, active-high reset
//   valid         start request, sampled only while idle
//   multiplicand  signed operand M, captured at acceptance
//   multiplier    signed operand Q, captured at acceptance
//   mult_result   signed 2N-bit product, held until the next completion
//   mult_ready    one-cycle pulse while a new mult_result is presented
//   busy          high while an operation is calculating or completing
// -----------------------------------------------------------------------------
module booth_multiplier #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [N-1:0]     multiplicand,
  input  logic [N-1:0]     multiplier,
  output logic [2*N-1:0]   mult_result,
  output logic             mult_ready,
  output logic             busy
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;

  logic [N:0]       a_reg;       // accumulator, one guard bit wider than N
  logic [N:0]       m_reg;       // sign-extended multiplicand
  logic [N-1:0]     q_reg;       // multiplier, shifted out LSB first
  logic             q_m1_reg;    // Booth extra bit q_-1
  logic [CW-1:0]    cnt_reg;     // iterations completed so far
  logic [2*N-1:0]   result_reg;

  logic [N:0]       sum;
  logic [N:0]       a_shift;
  logic [N-1:0]     q_shift;
  logic             last_iter;

  // One Booth step: conditional add/subtract, then arithmetic right shift
  // of the concatenation {A, Q, q_-1}.
  always_comb begin
    sum = a_reg;
    unique case ({q_reg[0], q_m1_reg})
      2'b01:   sum = a_reg + m_reg;
      2'b10:   sum = a_reg - m_reg;
      default: sum = a_reg;
    endcase
    a_shift   = {sum[N], sum[N:1]};
    q_shift   = {sum[0], q_reg[N-1:1]};
    last_iter = (cnt_reg == CW'(N - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (valid) state_next = CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg      <= '0;
      m_reg      <= '0;
      q_reg      <= '0;
      q_m1_reg   <= 1'b0;
      cnt_reg    <= '0;
      result_reg <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (valid) begin
            a_reg    <= '0;
            m_reg    <= {multiplicand[N-1], multiplicand};
            q_reg    <= multiplier;
            q_m1_reg <= 1'b0;
            cnt_reg  <= '0;
          end
        end
        CALC: begin
          a_reg    <= a_shift;
          q_reg    <= q_shift;
          q_m1_reg <= q_reg[0];
          // The counter saturates naturally: the last iteration leaves CALC,
          // so it is never incremented past N-1.
          if (!last_iter) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
          if (last_iter) begin
            // The product is the low 2N bits of the post-shift {A, Q}.
            result_reg <= {a_shift[N-1:0], q_shift};
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    mult_result = result_reg;
    mult_ready  = (state_reg == DONE);
    busy        = (state_reg != IDLE);
  end

endmodule
